// File: rtl/color_bar_pkg.sv
// rtl/color_bar_pkg.sv - shared constants and colour table for the colour-bar timing generator
package color_bar_pkg;

   localparam int VH_BITWIDTH_DEF = 13;
   localparam int NUM_BARS        = 8;
   localparam int BAR_IDX_W       = 3;

   // Colour masks as {R,G,B}; each bit expands to an all-ones or all-zeros component
   localparam logic [2:0] MASK_WHITE   = 3'b111;
   localparam logic [2:0] MASK_YELLOW  = 3'b110;
   localparam logic [2:0] MASK_CYAN    = 3'b011;
   localparam logic [2:0] MASK_GREEN   = 3'b010;
   localparam logic [2:0] MASK_MAGENTA = 3'b101;
   localparam logic [2:0] MASK_RED     = 3'b100;
   localparam logic [2:0] MASK_BLUE    = 3'b001;
   localparam logic [2:0] MASK_BLACK   = 3'b000;

   function automatic logic [2:0] bar_rgb_mask(input logic [BAR_IDX_W-1:0] idx);
      logic [2:0] m;
      case (idx)
         3'd0:    m = MASK_WHITE;
         3'd1:    m = MASK_YELLOW;
         3'd2:    m = MASK_CYAN;
         3'd3:    m = MASK_GREEN;
         3'd4:    m = MASK_MAGENTA;
         3'd5:    m = MASK_RED;
         3'd6:    m = MASK_BLUE;
         default: m = MASK_BLACK;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/color_bar_lut.sv
// rtl/color_bar_lut.sv - combinational bar index to {R,G,B} pixel lookup
module color_bar_lut
   import color_bar_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [BAR_IDX_W-1:0]    idx,
   output logic [3*DATA_WIDTH-1:0] rgb
);

   // Expand the 3-bit colour mask into full-width components
   always_comb begin
      logic [2:0] m;
      m   = bar_rgb_mask(idx);
      rgb = {{DATA_WIDTH{m[2]}}, {DATA_WIDTH{m[1]}}, {DATA_WIDTH{m[0]}}};
   end

endmodule

// File: rtl/color_bar_timing_gen.sv
// rtl/color_bar_timing_gen.sv - H/V counts to hs/vs/de/RGB colour-bar stream, 2-stage pipeline; optional COLOR_BAR_SCROLL_EN
module color_bar_timing_gen
   import color_bar_pkg::*;
#(
   parameter int VH_BITWIDTH = VH_BITWIDTH_DEF,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic [VH_BITWIDTH-1:0]  h_cnt,
   input  logic [VH_BITWIDTH-1:0]  v_cnt,
   input  logic [VH_BITWIDTH-1:0]  h_active,
   input  logic [VH_BITWIDTH-1:0]  h_sync_start,
   input  logic [VH_BITWIDTH-1:0]  h_sync_end,
   input  logic [VH_BITWIDTH-1:0]  v_active,
   input  logic [VH_BITWIDTH-1:0]  v_sync_start,
   input  logic [VH_BITWIDTH-1:0]  v_sync_end,
   input  logic                    hs_pol,
   input  logic                    vs_pol,
   output logic                    vid_hs,
   output logic                    vid_vs,
   output logic                    vid_de,
   output logic [3*DATA_WIDTH-1:0] vid_data,
   output logic                    frame_start
);

   localparam logic [VH_BITWIDTH-1:0] ONE      = VH_BITWIDTH'(1);
   localparam logic [BAR_IDX_W-1:0]   LAST_BAR = BAR_IDX_W'(NUM_BARS - 1);

   logic                    line_start, first_pixel, pix_active, hs_active, vs_active;
   logic [VH_BITWIDTH-1:0]  bar_w_calc, bar_w_r, cur_w, pix_cnt_r, cur_pix;
   logic [BAR_IDX_W-1:0]    bar_idx_r, cur_idx, next_idx, start_idx;
   logic                    de_s1, hs_s1, vs_s1, fs_s1;
   logic [BAR_IDX_W-1:0]    idx_s1;
   logic [3*DATA_WIDTH-1:0] rgb_s1;

`ifdef COLOR_BAR_SCROLL_EN
   logic [7:0] frame_cnt;

   // Frame counter advances as each frame_start pulse leaves the pipeline
   always_ff @(posedge clk) begin
      if (rst)
         frame_cnt <= '0;
      else if (ce && fs_s1)
         frame_cnt <= frame_cnt + 8'd1;
   end

   // Bars shift by one position every 16 frames
   assign start_idx = BAR_IDX_W'(frame_cnt >> 4);
`else
   assign start_idx = '0;
`endif

   // Decode the incoming position; at h_cnt==0 the tracker restarts from fresh values
   always_comb begin
      line_start  = (h_cnt == '0);
      first_pixel = line_start && (v_cnt == '0);
      pix_active  = (h_cnt < h_active) && (v_cnt < v_active);
      hs_active   = (h_cnt >= h_sync_start) && (h_cnt < h_sync_end);
      vs_active   = (v_cnt >= v_sync_start) && (v_cnt < v_sync_end);
      bar_w_calc  = h_active >> 3;
      if (bar_w_calc == '0)
         bar_w_calc = ONE;
      cur_w   = line_start ? bar_w_calc : bar_w_r;
      cur_pix = line_start ? '0 : pix_cnt_r;
      cur_idx = line_start ? start_idx : bar_idx_r;
`ifdef COLOR_BAR_SCROLL_EN
      next_idx = (cur_idx == LAST_BAR) ? '0 : cur_idx + 1'b1;
`else
      next_idx = (cur_idx == LAST_BAR) ? LAST_BAR : cur_idx + 1'b1;
`endif
   end

   // Bar tracker: count pixels within the current bar, step to the next bar at bar_w
   always_ff @(posedge clk) begin
      if (rst) begin
         bar_w_r   <= ONE;
         pix_cnt_r <= '0;
         bar_idx_r <= '0;
      end else if (ce) begin
         bar_w_r <= cur_w;
         if (pix_active && (cur_pix == cur_w - ONE)) begin
            pix_cnt_r <= '0;
            bar_idx_r <= next_idx;
         end else if (pix_active) begin
            pix_cnt_r <= cur_pix + ONE;
            bar_idx_r <= cur_idx;
         end else begin
            pix_cnt_r <= cur_pix;
            bar_idx_r <= cur_idx;
         end
      end
   end

   // Stage 1: register timing decisions and the bar index for this pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         de_s1  <= 1'b0;
         hs_s1  <= ~hs_pol;
         vs_s1  <= ~vs_pol;
         fs_s1  <= 1'b0;
         idx_s1 <= '0;
      end else if (ce) begin
         de_s1  <= pix_active;
         hs_s1  <= hs_active ? hs_pol : ~hs_pol;
         vs_s1  <= vs_active ? vs_pol : ~vs_pol;
         fs_s1  <= first_pixel;
         idx_s1 <= cur_idx;
      end
   end

   color_bar_lut #(.DATA_WIDTH(DATA_WIDTH)) u_lut (
      .idx (idx_s1),
      .rgb (rgb_s1)
   );

   // Stage 2: output registers, pixel data blanked outside the active area
   always_ff @(posedge clk) begin
      if (rst) begin
         vid_de      <= 1'b0;
         vid_hs      <= ~hs_pol;
         vid_vs      <= ~vs_pol;
         frame_start <= 1'b0;
         vid_data    <= '0;
      end else if (ce) begin
         vid_de      <= de_s1;
         vid_hs      <= hs_s1;
         vid_vs      <= vs_s1;
         frame_start <= fs_s1;
         vid_data    <= de_s1 ? rgb_s1 : '0;
      end
   end

endmodule

// File: tb/tb_color_bar_timing_gen.sv
// tb/tb_color_bar_timing_gen.sv - self-checking bench with a pixel-level reference model
module tb_color_bar_timing_gen;

   logic        clk = 1'b0;
   logic        rst, ce, hs_pol, vs_pol;
   logic [12:0] h_cnt, v_cnt, h_active, h_sync_start, h_sync_end;
   logic [12:0] v_active, v_sync_start, v_sync_end;
   logic        vid_hs, vid_vs, vid_de, frame_start;
   logic [23:0] vid_data;

   always #5 clk = ~clk;

   color_bar_timing_gen dut (
      .clk(clk), .rst(rst), .ce(ce), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .h_active(h_active), .h_sync_start(h_sync_start), .h_sync_end(h_sync_end),
      .v_active(v_active), .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
      .hs_pol(hs_pol), .vs_pol(vs_pol), .vid_hs(vid_hs), .vid_vs(vid_vs),
      .vid_de(vid_de), .vid_data(vid_data), .frame_start(frame_start)
   );

   typedef struct packed {
      logic        hs, vs, de, fs, dchk;
      logic [23:0] data;
   } exp_t;

   logic [23:0] colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   exp_t s1, s2;
   int   vectors = 0, miscompares = 0;
   int   frames_seen = 0, line_bw = 1, line_start_idx = 0;
   bit   line_ok = 0, count_en = 0;
   int   de_count, hs_count;

   // Reference: each ce-qualified input pixel produces its expected output two ce cycles later
   task automatic model_edge();
      exp_t e;
      int   bar;
      if (rst) begin
         e = '0; e.hs = ~hs_pol; e.vs = ~vs_pol; e.dchk = 1'b1;
         s1 = e; s2 = e; line_ok = 0; frames_seen = 0;
      end else if (ce) begin
         if (h_cnt == 0) begin
            line_ok = 1;
            line_bw = (h_active / 8 == 0) ? 1 : int'(h_active) / 8;
`ifdef COLOR_BAR_SCROLL_EN
            line_start_idx = (frames_seen / 16) % 8;
`else
            line_start_idx = 0;
`endif
         end
         e = '0;
         e.de = (h_cnt < h_active) && (v_cnt < v_active);
         e.hs = (h_cnt >= h_sync_start && h_cnt < h_sync_end) ? hs_pol : ~hs_pol;
         e.vs = (v_cnt >= v_sync_start && v_cnt < v_sync_end) ? vs_pol : ~vs_pol;
         bar = line_start_idx + int'(h_cnt) / line_bw;
`ifdef COLOR_BAR_SCROLL_EN
         bar = bar % 8;
`else
         if (bar > 7) bar = 7;
`endif
         e.data = e.de ? colors[bar] : 24'h0;
         e.dchk = !e.de || line_ok;
         e.fs   = (h_cnt == 0) && (v_cnt == 0);
         if (e.fs) frames_seen++;
         s2 = s1;
         s1 = e;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      vectors++;
      assert (vid_hs === s2.hs) else begin
         miscompares++; $error("FAIL hs h=%0d v=%0d observed %b expected %b", h_cnt, v_cnt, vid_hs, s2.hs);
      end
      assert (vid_vs === s2.vs) else begin
         miscompares++; $error("FAIL vs h=%0d v=%0d observed %b expected %b", h_cnt, v_cnt, vid_vs, s2.vs);
      end
      assert (vid_de === s2.de) else begin
         miscompares++; $error("FAIL de h=%0d v=%0d observed %b expected %b", h_cnt, v_cnt, vid_de, s2.de);
      end
      assert (frame_start === s2.fs) else begin
         miscompares++; $error("FAIL frame_start h=%0d v=%0d observed %b expected %b", h_cnt, v_cnt, frame_start, s2.fs);
      end
      if (s2.dchk) begin
         assert (vid_data === s2.data) else begin
            miscompares++; $error("FAIL data h=%0d v=%0d observed %h expected %h", h_cnt, v_cnt, vid_data, s2.data);
         end
      end
      if (count_en) begin
         de_count += int'(vid_de);
         hs_count += int'(vid_hs == hs_pol);
      end
   endtask

   // One line of counts; h advances only on ce; optional 2-cycle reset at rst_at
   task automatic run_line(input int v, input int ht, input int cep, input int rst_at);
      int h = 0;
      while (h < ht) begin
         h_cnt = 13'(h);
         v_cnt = 13'(v);
         rst   = (h == rst_at) || (rst_at >= 0 && h == rst_at + 1);
         ce    = rst ? 1'b1 : ($urandom_range(99) < cep);
         tick();
         if (ce) h++;
      end
      rst = 1'b0;
   endtask

   task automatic set_timing(input int ha, input int hss, input int hse,
                             input int va, input int vss, input int vse);
      h_active = 13'(ha); h_sync_start = 13'(hss); h_sync_end = 13'(hse);
      v_active = 13'(va); v_sync_start = 13'(vss); v_sync_end = 13'(vse);
   endtask

   initial begin
      int ht, vt;
      rst = 1'b1; ce = 1'b0; hs_pol = 1'b1; vs_pol = 1'b1;
      h_cnt = 13'd1649; v_cnt = 13'd749;
      set_timing(1280, 1390, 1430, 720, 725, 730);
      tick(); tick();
      rst = 1'b0;

      // 720p: upstream starts at the last count, then wraps to (0,0)
      ce = 1'b1; tick();
      de_count = 0; hs_count = 0; count_en = 1;
      run_line(0, 1650, 100, -1);
      count_en = 0;
      vectors++;
      assert (de_count === 1280) else begin
         miscompares++; $error("FAIL de_per_line observed %0d expected %0d", de_count, 1280);
      end
      vectors++;
      assert (hs_count === 40) else begin
         miscompares++; $error("FAIL hs_width observed %0d expected %0d", hs_count, 40);
      end
      run_line(1, 1650, 80, -1);
      run_line(726, 1650, 90, -1);
      run_line(720, 1650, 100, -1);

      // Negative polarity, then an hs window that is empty
      hs_pol = 1'b0; vs_pol = 1'b0;
      run_line(727, 1650, 100, -1);
      run_line(5, 1650, 100, -1);
      set_timing(1280, 1400, 1400, 720, 725, 730);
      run_line(6, 1650, 100, -1);
      hs_pol = 1'b1; vs_pol = 1'b1;
      set_timing(1280, 1390, 1430, 720, 725, 730);
      run_line(7, 1650, 100, -1);

      // Reset mid-line, then a clean line
      run_line(8, 1650, 100, 600);
      run_line(9, 1650, 100, -1);

      // Remainder pixels land in the last bar; tiny line uses bar width 1
      set_timing(1283, 1390, 1430, 720, 725, 730);
      run_line(10, 1650, 100, -1);
      set_timing(5, 8, 10, 2, 2, 3);
      for (int v = 0; v < 3; v++) run_line(v, 12, 85, -1);

      // 17 short frames: bar positions per frame (scrolling when enabled)
      set_timing(16, 18, 20, 2, 2, 3);
      for (int f = 0; f < 17; f++)
         for (int v = 0; v < 3; v++) run_line(v, 24, 100, -1);

      // Random timings, polarities and ce gaps
      for (int f = 0; f < 20; f++) begin
         ht = $urandom_range(48, 16);
         vt = $urandom_range(6, 3);
         set_timing($urandom_range(ht, 1), $urandom_range(ht, 0), $urandom_range(ht, 0),
                    $urandom_range(vt, 1), $urandom_range(vt, 0), $urandom_range(vt, 0));
         hs_pol = 1'($urandom_range(1));
         vs_pol = 1'($urandom_range(1));
         for (int v = 0; v < vt; v++) run_line(v, ht, 70, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
